// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: BTB-based branch predictor with ID-stage redirect, flush and table training
//   clk, rst                         clock, asynchronous active-high reset
//   pcF -> predTakenF, predTargetF   zero-latency IF lookup
//   stallD, pcD, opCodeD,            ID-stage resolution inputs (beq=4, bne=5, j=2)
//   compResultD, targetD
//   redirectD, redirectPCD, flushD   corrective redirect on mispredict
//   mispredCount                     saturating redirect counter
module branch_predict_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pcF,
    output logic                 predTakenF,
    output logic [31:0]          predTargetF,
    input  logic                 stallD,
    input  logic [31:0]          pcD,
    input  logic [5:0]           opCodeD,
    input  logic                 compResultD,
    input  logic [31:0]          targetD,
    output logic                 redirectD,
    output logic [31:0]          redirectPCD,
    output logic                 flushD,
    output logic [CNT_WIDTH-1:0] mispredCount
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    logic                  valid_q  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];
    logic                  pred_taken_q, pred_taken_d;
    logic [31:0]           pred_target_q, pred_target_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [INDEX_BITS-1:0] idx_f, idx_d;
    logic [TAG_W-1:0]      tag_f, tag_d;
    logic                  hit_f, hit_d, is_br, is_j, act_taken;
    logic                  entry_we, entry_valid_d;
    logic [31:0]           entry_target_d;
    logic [1:0]            entry_ctr_d;
    logic                  unused_pc_lsbs;

    assign idx_f = pcF[INDEX_BITS+1:2];
    assign tag_f = pcF[31:INDEX_BITS+2];
    assign idx_d = pcD[INDEX_BITS+1:2];
    assign tag_d = pcD[31:INDEX_BITS+2];
    assign unused_pc_lsbs = ^{pcF[1:0], pcD[1:0]};

    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_d       = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
    assign predTakenF  = hit_f && ctr_q[idx_f][1];
    assign predTargetF = predTakenF ? target_q[idx_f] : 32'd0;

    assign is_br     = (opCodeD == 6'd4) || (opCodeD == 6'd5);
    assign is_j      = (opCodeD == 6'd2);
    assign act_taken = ((opCodeD == 6'd4) && compResultD) || ((opCodeD == 6'd5) && !compResultD) || is_j;

    // Gated by rst so the outputs drop the moment reset is asserted, even with a mispredict in ID
    assign redirectD   = !rst && !stallD &&
                         (act_taken ? (!pred_taken_q || (pred_target_q != targetD)) : pred_taken_q);
    assign redirectPCD = redirectD ? (act_taken ? targetD : pcD + 32'd4) : 32'd0;
    assign flushD      = redirectD;
    assign mispredCount = cnt_q;

    assign pred_taken_d  = redirectD ? 1'b0  : (stallD ? pred_taken_q  : predTakenF);
    assign pred_target_d = redirectD ? 32'd0 : (stallD ? pred_target_q : predTargetF);
    assign cnt_d         = (redirectD && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        entry_we       = 1'b0;
        entry_valid_d  = 1'b1;
        entry_target_d = target_q[idx_d];
        entry_ctr_d    = ctr_q[idx_d];
        if (!stallD) begin
            if (is_j) begin
                entry_we       = 1'b1;
                entry_target_d = targetD;
                entry_ctr_d    = 2'd3;
            end else if (is_br && hit_d) begin
                entry_we       = 1'b1;
                entry_target_d = act_taken ? targetD : target_q[idx_d];
                entry_ctr_d    = act_taken ? ctr_q[idx_d] + {1'b0, ctr_q[idx_d] != 2'd3}
                                           : ctr_q[idx_d] - {1'b0, ctr_q[idx_d] != 2'd0};
            end else if (is_br && act_taken) begin
                entry_we       = 1'b1;
                entry_target_d = targetD;
                entry_ctr_d    = 2'd2;
            end else if (!is_br && hit_d) begin
                // A non-branch that hits is an alias; drop the entry so it stops predicting
                entry_we       = 1'b1;
                entry_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd1;
            end
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            cnt_q         <= '0;
        end else begin
            if (entry_we) begin
                valid_q[idx_d]  <= entry_valid_d;
                tag_q[idx_d]    <= tag_d;
                target_q[idx_d] <= entry_target_d;
                ctr_q[idx_d]    <= entry_ctr_d;
            end
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            cnt_q         <= cnt_d;
        end
    end
endmodule
